// File: rtl/multicycle_cpu_core.sv
// Multicycle 16-bit-instruction CPU core: loadable IMEM, 8-entry register file, ALU, FSM control.
// Optional MUL on op 9 when MULTICYCLE_CPU_MUL_EN is defined; otherwise op 9 is a NOP.
module multicycle_cpu_core #(
    parameter int DATA_W     = 32,
    parameter int IMEM_DEPTH = 64,
    localparam int PC_W      = $clog2(IMEM_DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              imem_we,
    input  logic [PC_W-1:0]   imem_waddr,
    input  logic [15:0]       imem_wdata,
    input  logic              run,
    output logic              halted,
    output logic [PC_W-1:0]   pc,
    output logic [DATA_W-1:0] gpr0,
    output logic [31:0]       retired
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXECUTE, S_WRITEBACK, S_HALT
    } state_t;

    localparam logic [3:0]      OP_BEQ  = 4'h7;
    localparam logic [3:0]      OP_JMP  = 4'h8;
    localparam logic [3:0]      OP_HALT = 4'hF;
    localparam logic [PC_W-1:0] PC_ONE  = 1;

    state_t                   state;
    logic [15:0]              imem [IMEM_DEPTH];
    logic signed [DATA_W-1:0] rf [8];

    logic [15:0]              ir_p0;
    logic signed [DATA_W-1:0] opa_p1, opb_p1;
    logic signed [DATA_W-1:0] res_p2;
    logic [PC_W-1:0]          npc_p2;

    logic [3:0]               op;
    logic [2:0]               rd, rs, rt;
    logic signed [DATA_W-1:0] imm_sx;
    logic [PC_W-1:0]          br_off;

    assign op     = ir_p0[15:12];
    assign rd     = ir_p0[11:9];
    assign rs     = ir_p0[8:6];
    assign rt     = ir_p0[5:3];
    assign imm_sx = DATA_W'($signed(ir_p0[5:0]));
    assign br_off = PC_W'($signed(ir_p0[5:0]));

    assign gpr0 = rf[0];

    function automatic logic signed [DATA_W-1:0] alu(
        input logic [3:0]               f,
        input logic signed [DATA_W-1:0] a,
        input logic signed [DATA_W-1:0] b,
        input logic signed [DATA_W-1:0] imm
    );
        case (f)
            4'h1:    return a + b;
            4'h2:    return a - b;
            4'h3:    return a & b;
            4'h4:    return a | b;
            4'h5:    return a ^ b;
            4'h6:    return a + imm;
`ifdef MULTICYCLE_CPU_MUL_EN
            4'h9:    return a * b;
`endif
            default: return '0;
        endcase
    endfunction

    function automatic logic writes_rd(input logic [3:0] f);
`ifdef MULTICYCLE_CPU_MUL_EN
        return (f >= 4'h1 && f <= 4'h6) || f == 4'h9;
`else
        return f >= 4'h1 && f <= 4'h6;
`endif
    endfunction

    // Instruction memory is never reset; writes only land while the core is parked.
    always_ff @(posedge clk) begin
        if (!reset && imem_we && (state == S_IDLE || state == S_HALT))
            imem[imem_waddr] <= imem_wdata;
    end

    // FETCH -> DECODE -> EXECUTE datapath registers (no reset; control gates their use)
    always_ff @(posedge clk) begin
        case (state)
            S_FETCH: ir_p0 <= imem[pc];
            S_DECODE: begin
                opa_p1 <= rf[rs];
                opb_p1 <= (op == OP_BEQ) ? rf[rd] : rf[rt];
            end
            S_EXECUTE: begin
                res_p2 <= alu(op, opa_p1, opb_p1, imm_sx);
                if (op == OP_BEQ && opa_p1 == opb_p1)
                    npc_p2 <= pc + PC_ONE + br_off;
                else if (op == OP_JMP)
                    npc_p2 <= ir_p0[PC_W-1:0];
                else
                    npc_p2 <= pc + PC_ONE;
            end
            default: ;
        endcase
    end

    // Control, architectural state and WRITEBACK commit
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            pc      <= '0;
            retired <= '0;
            halted  <= 1'b0;
            for (int i = 0; i < 8; i++) rf[i] <= '0;
        end else begin
            case (state)
                S_IDLE:    if (run) state <= S_FETCH;
                S_FETCH:   state <= S_DECODE;
                S_DECODE:  state <= S_EXECUTE;
                S_EXECUTE: state <= S_WRITEBACK;
                S_WRITEBACK: begin
                    if (writes_rd(op)) rf[rd] <= res_p2;
                    retired <= retired + 32'd1;
                    if (op == OP_HALT) begin
                        halted <= 1'b1;
                        state  <= S_HALT;
                    end else begin
                        pc    <= npc_p2;
                        state <= S_FETCH;
                    end
                end
                S_HALT: begin
                    if (run) begin
                        pc     <= '0;
                        halted <= 1'b0;
                        state  <= S_FETCH;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
